// File: rtl/lcd_hd44780_receiver.sv
// LCD-side HD44780 model on the 4-bit bus. It samples nibbles on falling edges of E and runs the
// 8/4-bit boot handshake. It then decodes instructions and tracks DDRAM, AC and busy, and answers busy/AC reads.
module lcd_hd44780_receiver #(
    parameter int unsigned POWER_CYCLES = 750000,
    parameter int unsigned CMD_CYCLES   = 2000,
    parameter int unsigned CLEAR_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [3:0] lcd_d,
    output logic [3:0] lcd_d_out,
    output logic       lcd_d_oe,
    output logic       busy,
    output logic [6:0] ac,
    output logic       mode_4bit,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       byte_valid,
    output logic       byte_rs,
    output logic [7:0] byte_data,
    output logic       protocol_err,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_char
);
    localparam int unsigned BMAX = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
    localparam int PW = $clog2(POWER_CYCLES + 1);
    localparam int BW = $clog2(BMAX + 1);

    typedef enum logic [1:0] {S_PWR, S_BOOT, S_HI, S_LO} state_e;

    logic [2:0]       e_sync_q, rs_sync_q, rw_sync_q;
    logic [2:0][3:0]  d_sync_q;
    logic             e_s2, e_s3, rs_s2, rs_s3, rw_s2, rw_s3, fall;
    logic [3:0]       d_s3;

    state_e           state_q, state_d;
    logic [PW-1:0]    pwr_cnt_q, pwr_cnt_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [3:0]       hi_nib_q, hi_nib_d;
    logic [6:0]       ac_q, ac_d;
    logic             id_q, id_d;
    logic [2:0]       dcb_q, dcb_d;
    logic             mode_q, mode_d, err_q, err_d;
    logic             bv_q, bv_d, brs_q, brs_d;
    logic [7:0]       bdata_q, bdata_d;
    logic [7:0]       byte_w;
    logic             mem_we, mem_clr;
    logic [7:0]       mem_q [0:127];
    logic [7:0]       dbg_q;

    assign e_s2   = e_sync_q[1];
    assign e_s3   = e_sync_q[2];
    assign rs_s2  = rs_sync_q[1];
    assign rs_s3  = rs_sync_q[2];
    assign rw_s2  = rw_sync_q[1];
    assign rw_s3  = rw_sync_q[2];
    assign d_s3   = d_sync_q[2];
    assign fall   = e_s3 & ~e_s2;
    assign byte_w = {hi_nib_q, d_s3};

    // Busy covers the power-up wait as well as the instruction execution window.
    assign busy = (state_q == S_PWR) || (bcnt_q != '0);

    always_comb begin
        state_d   = state_q;
        pwr_cnt_d = pwr_cnt_q;
        bcnt_d    = (bcnt_q != '0) ? bcnt_q - BW'(1) : bcnt_q;
        hi_nib_d  = hi_nib_q;
        ac_d      = ac_q;
        id_d      = id_q;
        dcb_d     = dcb_q;
        mode_d    = mode_q;
        err_d     = err_q;
        bv_d      = 1'b0;
        brs_d     = brs_q;
        bdata_d   = bdata_q;
        mem_we    = 1'b0;
        mem_clr   = 1'b0;
        unique case (state_q)
            S_PWR: begin
                if (pwr_cnt_q == '0) state_d = S_BOOT;
                else                 pwr_cnt_d = pwr_cnt_q - PW'(1);
                if (fall) err_d = 1'b1;
            end
            S_BOOT: if (fall) begin
                if (rw_s3 || rs_s3 || busy || !(d_s3 == 4'h3 || d_s3 == 4'h2)) begin
                    err_d = 1'b1;
                end else begin
                    bcnt_d = BW'(CMD_CYCLES);
                    if (d_s3 == 4'h2) begin
                        state_d = S_HI;
                        mode_d  = 1'b1;
                    end
                end
            end
            S_HI: if (fall) begin
                state_d  = S_LO;
                hi_nib_d = d_s3;
                if (rw_s3 && rs_s3) err_d = 1'b1;
            end
            S_LO: if (fall) begin
                // The phase toggles on every strobe so a dropped byte cannot misalign the stream.
                state_d = S_HI;
                if (rw_s3) begin
                    if (rs_s3) err_d = 1'b1;
                end else if (busy) begin
                    err_d = 1'b1;
                end else begin
                    bv_d    = 1'b1;
                    brs_d   = rs_s3;
                    bdata_d = byte_w;
                    bcnt_d  = BW'(CMD_CYCLES);
                    if (rs_s3) begin
                        mem_we = 1'b1;
                        ac_d   = id_q ? ac_q + 7'd1 : ac_q - 7'd1;
                    end else begin
                        priority casez (byte_w)
                            8'b1???????: ac_d = byte_w[6:0];
                            8'b01??????: ;
                            8'b001?????: if (byte_w[4]) err_d = 1'b1;
                            8'b0001????: if (!byte_w[3]) ac_d = byte_w[2] ? ac_q + 7'd1 : ac_q - 7'd1;
                            8'b00001???: dcb_d = byte_w[2:0];
                            8'b000001??: id_d = byte_w[1];
                            8'b0000001?: begin
                                ac_d   = 7'd0;
                                bcnt_d = BW'(CLEAR_CYCLES);
                            end
                            8'b00000001: begin
                                mem_clr = 1'b1;
                                ac_d    = 7'd0;
                                id_d    = 1'b1;
                                bcnt_d  = BW'(CLEAR_CYCLES);
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_sync_q  <= '0;
            rs_sync_q <= '0;
            rw_sync_q <= '0;
            d_sync_q  <= '0;
            state_q   <= S_PWR;
            pwr_cnt_q <= PW'(POWER_CYCLES);
            bcnt_q    <= '0;
            hi_nib_q  <= '0;
            ac_q      <= '0;
            id_q      <= 1'b1;
            dcb_q     <= '0;
            mode_q    <= 1'b0;
            err_q     <= 1'b0;
            bv_q      <= 1'b0;
            brs_q     <= 1'b0;
            bdata_q   <= '0;
            dbg_q     <= '0;
        end else begin
            e_sync_q  <= {e_sync_q[1:0], lcd_e};
            rs_sync_q <= {rs_sync_q[1:0], lcd_rs};
            rw_sync_q <= {rw_sync_q[1:0], lcd_rw};
            d_sync_q  <= {d_sync_q[1:0], lcd_d};
            state_q   <= state_d;
            pwr_cnt_q <= pwr_cnt_d;
            bcnt_q    <= bcnt_d;
            hi_nib_q  <= hi_nib_d;
            ac_q      <= ac_d;
            id_q      <= id_d;
            dcb_q     <= dcb_d;
            mode_q    <= mode_d;
            err_q     <= err_d;
            bv_q      <= bv_d;
            brs_q     <= brs_d;
            bdata_q   <= bdata_d;
            dbg_q     <= mem_q[dbg_addr];
        end
    end

    // Clear Display fills the whole DDRAM in one cycle, well inside its busy window.
    always_ff @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 128; i++) mem_q[i] <= 8'h20;
        end else if (mem_we) begin
            mem_q[ac_q] <= byte_w;
        end
    end

    always_comb begin
        lcd_d_out = 4'h0;
        if (lcd_d_oe && !rs_s2) lcd_d_out = (state_q == S_LO) ? ac_q[3:0] : {busy, ac_q[6:4]};
    end

    assign lcd_d_oe     = rw_s2 & e_s2;
    assign ac           = ac_q;
    assign mode_4bit    = mode_q;
    assign display_on   = dcb_q[2];
    assign cursor_on    = dcb_q[1];
    assign blink_on     = dcb_q[0];
    assign byte_valid   = bv_q;
    assign byte_rs      = brs_q;
    assign byte_data    = bdata_q;
    assign protocol_err = err_q;
    assign dbg_char     = dbg_q;
endmodule

// File: tb/tb_lcd_hd44780_receiver.sv
// Bench for lcd_hd44780_receiver: drives the 4-bit bus like the controller and checks results
// against a byte-level LCD model (DDRAM array, integer AC, entry mode, display bits).
module tb_lcd_hd44780_receiver;
    localparam int PWR = 20, CMD = 10, CLR = 40;

    logic clk = 1'b0, reset = 1'b1;
    logic lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [3:0] lcd_d = 4'h0;
    logic [6:0] dbg_addr = 7'h0;
    logic [3:0] lcd_d_out;
    logic lcd_d_oe, busy, mode_4bit, display_on, cursor_on, blink_on;
    logic byte_valid, byte_rs, protocol_err;
    logic [6:0] ac;
    logic [7:0] byte_data, dbg_char;

    lcd_hd44780_receiver #(.POWER_CYCLES(PWR), .CMD_CYCLES(CMD), .CLEAR_CYCLES(CLR)) dut (
        .clk(clk), .reset(reset), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_d(lcd_d),
        .lcd_d_out(lcd_d_out), .lcd_d_oe(lcd_d_oe), .busy(busy), .ac(ac), .mode_4bit(mode_4bit),
        .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .byte_valid(byte_valid), .byte_rs(byte_rs), .byte_data(byte_data),
        .protocol_err(protocol_err), .dbg_addr(dbg_addr), .dbg_char(dbg_char));

    always #5 clk = ~clk;

    int vectors = 0, errors = 0;

    // Reference model state
    logic [7:0] m_mem [128];
    int         m_ac;
    bit         m_id;
    logic [2:0] m_dcb;
    logic [8:0] exp_q[$], got_q[$];

    always @(negedge clk) if (byte_valid) got_q.push_back({byte_rs, byte_data});

    task automatic m_apply(input logic rs, input logic [7:0] b);
        int v;
        v = b;
        exp_q.push_back({rs, b});
        if (rs) begin
            m_mem[m_ac] = b;
            m_ac = (m_ac + (m_id ? 1 : 127)) % 128;
        end else if (v >= 128) m_ac = v - 128;
        else if (v >= 32) ;
        else if (v >= 16) begin
            if (!b[3]) m_ac = (m_ac + (b[2] ? 1 : 127)) % 128;
        end else if (v >= 8) m_dcb = 3'(v % 8);
        else if (v >= 4) m_id = b[1];
        else if (v >= 2) m_ac = 0;
        else if (v == 1) begin
            for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
            m_ac = 0;
            m_id = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; lcd_e = 1'b0; lcd_rw = 1'b0; lcd_rs = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        got_q.delete(); exp_q.delete();
        m_ac = 0; m_id = 1'b1; m_dcb = 3'b000;
    endtask

    task automatic nib(input logic rs, input logic rw, input logic [3:0] d);
        @(posedge clk); #1 lcd_rs = rs; lcd_rw = rw; lcd_d = d; lcd_e = 1'b1;
        @(posedge clk); #1 lcd_e = 1'b0;
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b);
        nib(rs, 1'b0, b[7:4]);
        nib(rs, 1'b0, b[3:0]);
    endtask

    task automatic rd_nib(input logic rs, output logic oe, output logic [3:0] d);
        @(posedge clk); #1 lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); oe = lcd_d_oe; d = lcd_d_out;
        @(posedge clk); #1 lcd_e = 1'b0;
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        repeat (4) @(posedge clk);
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        vectors++;
        if (!ok) begin errors++; $display("FAIL wait_ready: busy still %b after 300 cycles, required 0", busy); end
    endtask

    task automatic wr(input logic rs, input logic [7:0] b);
        send_byte(rs, b);
        m_apply(rs, b);
        wait_ready();
    endtask

    task automatic dbg_rd(input logic [6:0] a, output logic [7:0] v);
        @(posedge clk); #1 dbg_addr = a;
        @(posedge clk); @(negedge clk); v = dbg_char;
    endtask

    task automatic boot_seq();
        wait_ready();
        for (int i = 0; i < 3; i++) begin nib(1'b0, 1'b0, 4'h3); wait_ready(); end
        nib(1'b0, 1'b0, 4'h2); wait_ready();
    endtask

    task automatic test_reset();
        int n = 0;
        do_reset();
        @(negedge clk);
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b required 1", busy); end
        vectors++; if (mode_4bit !== 1'b0) begin errors++; $display("FAIL reset_mode: got %b required 0", mode_4bit); end
        vectors++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", protocol_err); end
        vectors++; if (ac !== 7'h00) begin errors++; $display("FAIL reset_ac: got %h required 00", ac); end
        vectors++; if ({lcd_d_oe, byte_valid, display_on} !== 3'b000) begin
            errors++; $display("FAIL reset_outs: got %b required 000", {lcd_d_oe, byte_valid, display_on}); end
        for (int i = 0; i < 100 && busy; i++) begin n++; @(negedge clk); end
        vectors++; if (n < PWR - 1 || n > PWR + 2) begin
            errors++; $display("FAIL power_wait: busy held %0d cycles, required about %0d", n, PWR); end
        vectors++; if (mode_4bit !== 1'b0 || protocol_err !== 1'b0) begin
            errors++; $display("FAIL post_power: mode/err got %b%b required 00", mode_4bit, protocol_err); end
    endtask

    task automatic test_pwr_strobe();
        do_reset();
        repeat (4) @(posedge clk);
        nib(1'b0, 1'b0, 4'h3);
        repeat (5) @(posedge clk);
        @(negedge clk);
        vectors++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL pwr_strobe_err: got %b required 1", protocol_err); end
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL pwr_strobe_busy: got %b required 1", busy); end
        wait_ready();
        vectors++; if (mode_4bit !== 1'b0) begin errors++; $display("FAIL pwr_strobe_mode: got %b required 0", mode_4bit); end
        vectors++; if (got_q.size() != 0) begin errors++; $display("FAIL pwr_strobe_bv: got %0d pulses required 0", got_q.size()); end
    endtask

    task automatic test_boot_init();
        int n = 0;
        logic [7:0] v;
        do_reset();
        boot_seq();
        vectors++; if (mode_4bit !== 1'b1) begin errors++; $display("FAIL boot_mode: got %b required 1", mode_4bit); end
        wr(1'b0, 8'h28); wr(1'b0, 8'h06); wr(1'b0, 8'h0C);
        vectors++; if ({display_on, cursor_on, blink_on} !== 3'b100) begin
            errors++; $display("FAIL init_dcb: got %b required 100", {display_on, cursor_on, blink_on}); end
        send_byte(1'b0, 8'h01);
        m_apply(1'b0, 8'h01);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) n++;
            else if (n > 0) break;
        end
        vectors++; if (n != CLR) begin errors++; $display("FAIL clear_busy: held %0d cycles required %0d", n, CLR); end
        vectors++; if (ac !== 7'h00) begin errors++; $display("FAIL clear_ac: got %h required 00", ac); end
        for (int a = 0; a < 128; a++) begin
            dbg_rd(7'(a), v);
            vectors++; if (v !== 8'h20) begin errors++; $display("FAIL clear_ddram[%0d]: got %h required 20", a, v); end
        end
        vectors++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL init_err: got %b required 0", protocol_err); end
        vectors++; if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL init_bv_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL init_bv[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_data_write();
        logic [7:0] v;
        got_q.delete(); exp_q.delete();
        wr(1'b0, 8'h80); wr(1'b1, 8'h48); wr(1'b1, 8'h49);
        dbg_rd(7'h00, v);
        vectors++; if (v !== 8'h48) begin errors++; $display("FAIL data_ddram0: got %h required 48", v); end
        dbg_rd(7'h01, v);
        vectors++; if (v !== 8'h49) begin errors++; $display("FAIL data_ddram1: got %h required 49", v); end
        vectors++; if (ac !== 7'h02) begin errors++; $display("FAIL data_ac: got %h required 02", ac); end
        vectors++; if (got_q.size() != 3) begin errors++; $display("FAIL data_bv_count: got %0d required 3", got_q.size()); end
        else foreach (exp_q[i]) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL data_bv[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] v;
        wr(1'b0, 8'hFF); wr(1'b1, 8'h41);
        dbg_rd(7'h7F, v);
        vectors++; if (v !== 8'h41) begin errors++; $display("FAIL wrap_ddram: got %h required 41", v); end
        vectors++; if (ac !== 7'h00) begin errors++; $display("FAIL wrap_ac: got %h required 00", ac); end
    endtask

    task automatic test_random();
        logic [7:0] v, b;
        got_q.delete(); exp_q.delete();
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0: wr(1'b0, 8'h80 | 8'($urandom_range(0, 127)));
                1: wr(1'b0, 8'h04 | 8'($urandom_range(0, 3)));
                2: wr(1'b0, 8'h10 | 8'($urandom_range(0, 15)));
                3: wr(1'b0, 8'h08 | 8'($urandom_range(0, 7)));
                default: begin b = 8'($urandom_range(0, 255)); wr(1'b1, b); end
            endcase
        end
        vectors++; if (ac !== 7'(m_ac)) begin errors++; $display("FAIL rand_ac: got %h required %h", ac, 7'(m_ac)); end
        vectors++; if ({display_on, cursor_on, blink_on} !== m_dcb) begin
            errors++; $display("FAIL rand_dcb: got %b required %b", {display_on, cursor_on, blink_on}, m_dcb); end
        for (int a = 0; a < 128; a++) begin
            dbg_rd(7'(a), v);
            vectors++; if (v !== m_mem[a]) begin errors++; $display("FAIL rand_ddram[%0d]: got %h required %h", a, v, m_mem[a]); end
        end
        vectors++; if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_bv_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_bv[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_busy_read_and_drop();
        logic oe0, oe1;
        logic [3:0] n0, n1;
        logic [7:0] v;
        send_byte(1'b0, 8'hC0); m_apply(1'b0, 8'hC0);
        rd_nib(1'b0, oe0, n0);
        rd_nib(1'b0, oe1, n1);
        vectors++; if ({oe0, n0} !== 5'b1_1100) begin errors++; $display("FAIL busy_read_hi: got oe=%b d=%b required oe=1 d=1100", oe0, n0); end
        vectors++; if ({oe1, n1} !== 5'b1_0000) begin errors++; $display("FAIL busy_read_lo: got oe=%b d=%b required oe=1 d=0000", oe1, n1); end
        vectors++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL busy_read_err: got %b required 0", protocol_err); end
        wait_ready();
        got_q.delete(); exp_q.delete();
        send_byte(1'b0, 8'hC0); m_apply(1'b0, 8'hC0);
        send_byte(1'b1, 8'h41);
        wait_ready();
        vectors++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL drop_err: got %b required 1", protocol_err); end
        vectors++; if (ac !== 7'h40) begin errors++; $display("FAIL drop_ac: got %h required 40", ac); end
        dbg_rd(7'h40, v);
        vectors++; if (v !== m_mem[64]) begin errors++; $display("FAIL drop_ddram: got %h required %h", v, m_mem[64]); end
        vectors++; if (got_q.size() != 1 || got_q[0] !== 9'h0C0) begin
            errors++; $display("FAIL drop_bv: got %0d pulses required 1 (0c0)", got_q.size()); end
        wr(1'b1, 8'h5A);
        dbg_rd(7'h40, v);
        vectors++; if (v !== 8'h5A) begin errors++; $display("FAIL drop_realign: got %h required 5a", v); end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] v;
        nib(1'b0, 1'b0, 4'h4);
        repeat (4) @(posedge clk);
        do_reset();
        @(negedge clk);
        vectors++; if (protocol_err !== 1'b0 || mode_4bit !== 1'b0) begin
            errors++; $display("FAIL midreset_state: err/mode got %b%b required 00", protocol_err, mode_4bit); end
        boot_seq();
        wr(1'b0, 8'h28); wr(1'b0, 8'h06); wr(1'b0, 8'h0C); wr(1'b0, 8'h01);
        wr(1'b0, 8'h85); wr(1'b1, 8'h33);
        dbg_rd(7'h05, v);
        vectors++; if (v !== 8'h33) begin errors++; $display("FAIL midreset_ddram: got %h required 33", v); end
        vectors++; if (ac !== 7'h06) begin errors++; $display("FAIL midreset_ac: got %h required 06", ac); end
        vectors++; if (protocol_err !== 1'b0 || mode_4bit !== 1'b1) begin
            errors++; $display("FAIL midreset_final: err/mode got %b%b required 01", protocol_err, mode_4bit); end
        vectors++; if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL midreset_bv_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midreset_bv[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_pwr_strobe();
        test_boot_init();
        test_data_write();
        test_wrap();
        test_random();
        test_busy_read_and_drop();
        test_reset_mid_byte();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
